// File: rtl/alu_iterative_pkg.sv
// Shared op codes, widths and FSM encoding for the iterative ALU.
// Shifts are the only multi-cycle operations; everything else settles in one cycle.
package alu_iterative_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BNE = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Request/response bundle between the EX-stage control and the iterative ALU.
interface alu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, alu_ctrl, src1, src2,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, alu_ctrl, src1, src2,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_iterative_serial_shifter.sv
// One-bit-per-cycle shifter with a down-counter; captures operand, amount and direction at load.
// data_nxt is the value after the next step, so the caller can register the final result on the last step.
module alu_iterative_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               dir_right,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_nxt,
  output logic               last
);
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] count_q;
  logic               dir_q;
  logic               arith_q;

  // Arithmetic right shift keeps replicating the original sign bit, which stays in the MSB.
  assign data_nxt = dir_q ? {(arith_q & data_q[WIDTH-1]), data_q[WIDTH-1:1]}
                          : {data_q[WIDTH-2:0], 1'b0};
  assign last     = (count_q == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      count_q <= shamt;
      dir_q   <= dir_right;
      arith_q <= arith;
    end else if (step && (count_q != '0)) begin
      data_q  <= data_nxt;
      count_q <= count_q - SHAMT_W'(1);
    end
  end
endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, serial sll/sra at one bit per cycle.
// All outputs are registered; result/zero hold until the next done pulse.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic          clk,
  input  logic          rst,
  alu_iterative_if.slave bus
);
  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               zero_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   exec_result;
  logic               exec_zero;
  logic [WIDTH-1:0]   shift_nxt;
  logic               shift_last;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               go_shift;

  assign shamt    = bus.src2[SHAMT_W-1:0];
  // The done cycle is not busy, so a new request may be taken there.
  assign accept   = bus.start && (state != ST_SHIFT);
  assign go_shift = accept && is_shift(bus.alu_ctrl) && (shamt != '0);

  always_comb begin
    exec_result = '0;
    case (bus.alu_ctrl)
      ALU_ADD:          exec_result = bus.src1 + bus.src2;
      ALU_SUB, ALU_BNE: exec_result = bus.src1 - bus.src2;
      ALU_AND:          exec_result = bus.src1 & bus.src2;
      ALU_OR:           exec_result = bus.src1 | bus.src2;
      ALU_XOR:          exec_result = bus.src1 ^ bus.src2;
      ALU_SLT:          exec_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
      ALU_SLL, ALU_SRA: exec_result = bus.src1;
      default:          exec_result = '0;
    endcase
    exec_zero = (bus.alu_ctrl == ALU_BNE) ? (exec_result != '0) : (exec_result == '0);
  end

  alu_iterative_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (go_shift),
    .step      (state == ST_SHIFT),
    .dir_right (bus.alu_ctrl == ALU_SRA),
    .arith     (bus.alu_ctrl == ALU_SRA),
    .data_in   (bus.src1),
    .shamt     (shamt),
    .data_nxt  (shift_nxt),
    .last      (shift_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_SHIFT: begin
          if (shift_last) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= shift_nxt;
            zero_q   <= (shift_nxt == '0);
          end
        end
        default: begin
          if (go_shift) begin
            state  <= ST_SHIFT;
            busy_q <= 1'b1;
          end else if (accept) begin
            state    <= ST_EXEC;
            done_q   <= 1'b1;
            result_q <= exec_result;
            zero_q   <= exec_zero;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_iterative.sv
// Randomized and directed bench for alu_iterative against a plain-arithmetic reference model.
module tb_alu_iterative;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_iterative_if #(.WIDTH(32)) bus ();

  alu_iterative dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output int lat);
    int n;
    n = int'(b[4:0]);
    case (c)
      4'b0010:          r = a + b;
      4'b0110, 4'b1110: r = a - b;
      4'b0000:          r = a & b;
      4'b0001:          r = a | b;
      4'b0011:          r = a ^ b;
      4'b0111:          r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100:          r = a << n;
      4'b0101:          r = $unsigned($signed(a) >>> n);
      default:          r = 32'd0;
    endcase
    z   = (c == 4'b1110) ? (r != 0) : (r == 0);
    lat = ((c == 4'b0100) || (c == 4'b0101)) ? n + 1 : 1;
  endfunction

  task automatic drive_start(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.alu_ctrl = c;
    bus.src1     = a;
    bus.src2     = b;
  endtask

  // Call in the cycle where the request is being presented; returns inside its done cycle.
  task automatic monitor_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input bit chain, input logic [3:0] nc, input logic [31:0] na,
                            input logic [31:0] nb);
    logic [31:0] er;
    logic        ez;
    int          lat;
    int          bad;
    string       tag;
    ref_model(c, a, b, er, ez, lat);
    tag = $sformatf("op%b_a%h_b%h", c, a, b);
    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k < lat) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        bus.start    = 1'($urandom_range(0, 1));
        bus.alu_ctrl = 4'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
      end else begin
        check_eq({tag, "_busy_window"}, 32'(bad), 32'd0);
        check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check_eq({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check_eq({tag, "_result"}, bus.result, er);
        check_eq({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
        if (chain) drive_start(nc, na, nb);
        else bus.start = 1'b0;
      end
    end
  endtask

  task automatic run_single(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    drive_start(c, a, b);
    monitor_op(c, a, b, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check_eq($sformatf("op%b_single_done_pulse", c), {31'd0, bus.done}, 32'd0);
  endtask

  logic [3:0] codes [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                             4'b0110, 4'b0111, 4'b1110, 4'b1000, 4'b1111, 4'b1001};

  initial begin
    logic [3:0]  c0, c1;
    logic [31:0] a0, b0, a1, b1;
    int          done_seen;
    bit          chain;

    bus.start    = 1'b0;
    bus.alu_ctrl = 4'd0;
    bus.src1     = 32'd0;
    bus.src2     = 32'd0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_result", bus.result, 32'd0);
    check_eq("reset_zero", {31'd0, bus.zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_single(4'b0010, 32'h7FFF_FFFF, 32'd1);
    run_single(4'b0110, 32'd5, 32'd5);
    run_single(4'b1110, 32'd5, 32'd5);
    run_single(4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_single(4'b0111, 32'd1, 32'hFFFF_FFFF);
    run_single(4'b0101, 32'h8000_0000, 32'd31);
    run_single(4'b0101, 32'h1234_5678, 32'hFFFF_FFE0);
    run_single(4'b0100, 32'h0000_0001, 32'h0000_0023);

    // Reset in the second busy cycle of a 10-step shift: everything clears, no done follows.
    drive_start(4'b0100, 32'h0000_0003, 32'd10);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
    check_eq("midrst_result", bus.result, 32'd0);
    check_eq("midrst_zero", {31'd0, bus.zero}, 32'd0);
    done_seen = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
    end
    check_eq("midrst_no_done", 32'(done_seen), 32'd0);

    // Back-to-back: second request presented in the first one's done cycle.
    drive_start(4'b0100, 32'h0000_0005, 32'd4);
    monitor_op(4'b0100, 32'h0000_0005, 32'd4, 1'b1, 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    monitor_op(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 4'b0101, 32'h8000_0010, 32'd2);
    monitor_op(4'b0101, 32'h8000_0010, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);

    c0 = codes[$urandom_range(0, 11)];
    a0 = $urandom;
    b0 = $urandom;
    drive_start(c0, a0, b0);
    for (int i = 0; i < 80; i++) begin
      c1 = codes[$urandom_range(0, 11)];
      a1 = $urandom;
      b1 = $urandom;
      if ($urandom_range(0, 3) == 0) a1 = 32'd0;
      if ($urandom_range(0, 5) == 0) b1 = a1;
      chain = ($urandom_range(0, 1) == 1);
      monitor_op(c0, a0, b0, chain, c1, a1, b1);
      if (!chain) begin
        @(posedge clk);
        #1;
        check_eq("rand_done_pulse", {31'd0, bus.done}, 32'd0);
        drive_start(c1, a1, b1);
      end
      c0 = c1;
      a0 = a1;
      b0 = b1;
    end
    monitor_op(c0, a0, b0, 1'b0, 4'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
